// File: rtl/nn_cfg_pkg.sv
// Shared constants for the network configuration loader: register map,
// AXI response code and the sequencer state encoding.
package nn_cfg_pkg;

  localparam logic [31:0] REG_WEIGHT = 32'd0;
  localparam logic [31:0] REG_BIAS   = 32'd4;
  localparam logic [31:0] REG_LAYER  = 32'd12;
  localparam logic [31:0] REG_NEURON = 32'd16;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  typedef enum logic [3:0] {
    IDLE,
    WR_LAYER,
    WR_NEURON,
    FETCH_W,
    WR_W,
    FETCH_B,
    WR_B,
    ADVANCE,
    ERR
  } seq_state_e;

endpackage

// File: rtl/nn_config_sequencer_if.sv
// AXI4-Lite write channels between the sequencer (master) and the network's
// configuration port (slave). Read channels are not used by the loader.
interface nn_config_sequencer_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axil_single_write.sv
// One AXI4-Lite write at a time: address and data are issued together, each
// channel retires on its own ready, then the response is collected.
module axil_single_write
  import nn_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        err,
  nn_config_sequencer_if.master axi
);

  logic aw_fin;
  logic w_fin;

  // A channel counts as finished once its valid has dropped or is being accepted now.
  assign aw_fin = !axi.awvalid || axi.awready;
  assign w_fin  = !axi.wvalid  || axi.wready;

  assign done      = axi.bready && axi.bvalid;
  assign err       = done && (axi.bresp != BRESP_OKAY);
  assign axi.wstrb = 4'hF;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      axi.awaddr  <= '0;
      axi.wdata   <= '0;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
    end else if (!busy) begin
      if (go) begin
        busy        <= 1'b1;
        axi.awaddr  <= addr;
        axi.wdata   <= data;
        axi.awvalid <= 1'b1;
        axi.wvalid  <= 1'b1;
      end
    end else begin
      if (axi.awready) axi.awvalid <= 1'b0;
      if (axi.wready)  axi.wvalid  <= 1'b0;
      if (axi.bready && axi.bvalid) begin
        axi.bready <= 1'b0;
        busy       <= 1'b0;
      end else if (aw_fin && w_fin) begin
        axi.bready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_config_sequencer.sv
// Streams weights and biases from a config FIFO into nn_autoGen_top over
// AXI4-Lite: layer register, then per neuron the neuron register, weights, bias.
module nn_config_sequencer
  import nn_cfg_pkg::*;
#(
  parameter int                         NUM_LAYERS    = 4,
  parameter int                         DATA_WIDTH    = 16,
  parameter logic [16*NUM_LAYERS-1:0]   LAYER_NEURONS = {16'd10, 16'd10, 16'd30, 16'd30},
  parameter logic [16*NUM_LAYERS-1:0]   LAYER_WEIGHTS = {16'd10, 16'd30, 16'd30, 16'd784}
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            cur_layer,
  output logic [15:0]           cur_neuron,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  nn_config_sequencer_if.master m_axi
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TAB_N = 1 << IDX_W;

  seq_state_e            state_q;
  logic [7:0]            layer_q;
  logic [15:0]           neuron_q;
  logic [15:0]           widx_q;
  logic [DATA_WIDTH-1:0] word_q;

  logic [15:0]      neurons_tab [TAB_N];
  logic [15:0]      weights_tab [TAB_N];
  logic [IDX_W-1:0] tab_idx;
  logic [15:0]      last_neuron;
  logic [15:0]      last_widx;

  logic        wr_go;
  logic        wr_busy;
  logic        wr_done;
  logic        wr_err;
  logic        in_write;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // Unpack the per-layer counts; unused power-of-two padding rows hold 1.
  for (genvar i = 0; i < TAB_N; i++) begin : g_tab
    if (i < NUM_LAYERS) begin : g_used
      if (LAYER_NEURONS[16*i +: 16] == 16'd0 || LAYER_WEIGHTS[16*i +: 16] == 16'd0) begin : g_bad
        $error("nn_config_sequencer: zero neuron or weight count in layer %0d", i + 1);
      end
      assign neurons_tab[i] = LAYER_NEURONS[16*i +: 16];
      assign weights_tab[i] = LAYER_WEIGHTS[16*i +: 16];
    end else begin : g_pad
      assign neurons_tab[i] = 16'd1;
      assign weights_tab[i] = 16'd1;
    end
  end

  assign tab_idx     = IDX_W'(layer_q - 8'd1);
  assign last_neuron = neurons_tab[tab_idx] - 16'd1;
  assign last_widx   = weights_tab[tab_idx] - 16'd1;

  assign in_write   = (state_q == WR_LAYER) || (state_q == WR_NEURON) ||
                      (state_q == WR_W)     || (state_q == WR_B);
  assign wr_go      = in_write && !wr_busy;
  assign busy       = (state_q != IDLE) && (state_q != ERR);
  assign cfg_ready  = (state_q == FETCH_W) || (state_q == FETCH_B);
  assign cur_layer  = busy ? layer_q : 8'd0;
  assign cur_neuron = neuron_q;

  // NOTE: every always_comb output gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    wr_addr = REG_WEIGHT;
    wr_data = '0;
    case (state_q)
      WR_LAYER: begin
        wr_addr = REG_LAYER;
        wr_data = {24'd0, layer_q};
      end
      WR_NEURON: begin
        wr_addr = REG_NEURON;
        wr_data = {16'd0, neuron_q};
      end
      WR_W: begin
        wr_addr = REG_WEIGHT;
        wr_data = 32'(word_q);
      end
      WR_B: begin
        wr_addr = REG_BIAS;
        wr_data = 32'(word_q);
      end
      default: ;
    endcase
  end

  axil_single_write u_wr (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .go    (wr_go),
    .addr  (wr_addr),
    .data  (wr_data),
    .busy  (wr_busy),
    .done  (wr_done),
    .err   (wr_err),
    .axi   (m_axi)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q  <= IDLE;
      layer_q  <= '0;
      neuron_q <= '0;
      widx_q   <= '0;
      word_q   <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE, ERR: begin
          if (start) begin
            state_q  <= WR_LAYER;
            layer_q  <= 8'd1;
            neuron_q <= '0;
            widx_q   <= '0;
            error    <= 1'b0;
          end
        end
        WR_LAYER, WR_NEURON, WR_W, WR_B: begin
          if (wr_done) begin
            if (wr_err) begin
              state_q <= ERR;
              error   <= 1'b1;
            end else begin
              case (state_q)
                WR_LAYER:  state_q <= WR_NEURON;
                WR_NEURON: state_q <= FETCH_W;
                WR_W: begin
                  if (widx_q == last_widx) begin
                    state_q <= FETCH_B;
                  end else begin
                    widx_q  <= widx_q + 16'd1;
                    state_q <= FETCH_W;
                  end
                end
                default:   state_q <= ADVANCE;
              endcase
            end
          end
        end
        FETCH_W: begin
          if (cfg_valid) begin
            word_q  <= cfg_data;
            state_q <= WR_W;
          end
        end
        FETCH_B: begin
          if (cfg_valid) begin
            word_q  <= cfg_data;
            state_q <= WR_B;
          end
        end
        ADVANCE: begin
          if (neuron_q < last_neuron) begin
            neuron_q <= neuron_q + 16'd1;
            widx_q   <= '0;
            state_q  <= WR_NEURON;
          end else if (layer_q < 8'(NUM_LAYERS)) begin
            layer_q  <= layer_q + 8'd1;
            neuron_q <= '0;
            widx_q   <= '0;
            state_q  <= WR_LAYER;
          end else begin
            done    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_config_sequencer.sv
// Self-checking bench: a behavioural AXI4-Lite slave and stream source drive
// the loader; the expected write log is derived from the layer table.
module tb_nn_config_sequencer;

  localparam int          NL = 2;
  localparam logic [31:0] LN = {16'd2, 16'd2};
  localparam logic [31:0] LW = {16'd2, 16'd3};

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string name;
    int    aw_d;
    int    w_d;
    bit    rnd_d;
    int    gap;
    int    err_wr;
    int    restart_at;
    bit    seq_data;
    int    exp_cycles;
    bit    exp_done;
    bit    exp_error;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  cur_layer;
  logic [15:0] cur_neuron;
  logic [15:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;

  nn_config_sequencer_if m_axi ();

  nn_config_sequencer #(
    .NUM_LAYERS    (NL),
    .DATA_WIDTH    (16),
    .LAYER_NEURONS (LN),
    .LAYER_WEIGHTS (LW)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .cur_layer     (cur_layer),
    .cur_neuron    (cur_neuron),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .m_axi         (m_axi)
  );

  always #5 clk = ~clk;

  int model_neurons [NL] = '{2, 2};
  int model_weights [NL] = '{3, 2};

  int tests = 0;
  int fails = 0;

  wr_t         log_q[$];
  wr_t         exp_log[$];
  logic [15:0] stream[$];
  logic [15:0] src_q[$];

  int          aw_delay, w_delay, gap_mode, err_on_write;
  bit          rand_delay;
  int          aw_wait, w_wait, cyc;
  bit          aw_fire, w_fire, b_fire, aw_done, w_done, cfg_fire;
  logic [31:0] cap_addr, cap_data;
  int          done_cnt, consumed, proto_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference write sequence straight from the layer table and the stream.
  task automatic build_expected();
    int idx = 0;
    exp_log.delete();
    for (int k = 1; k <= NL; k++) begin
      exp_log.push_back('{addr: 32'd12, data: 32'(k)});
      for (int j = 0; j < model_neurons[k-1]; j++) begin
        exp_log.push_back('{addr: 32'd16, data: 32'(j)});
        for (int w = 0; w < model_weights[k-1]; w++) begin
          exp_log.push_back('{addr: 32'd0, data: {16'd0, stream[idx]}});
          idx++;
        end
        exp_log.push_back('{addr: 32'd4, data: {16'd0, stream[idx]}});
        idx++;
      end
    end
  endtask

  task automatic prep_stream(input bit seq);
    int total = 0;
    for (int k = 0; k < NL; k++) total += model_neurons[k] * (model_weights[k] + 1);
    stream.delete();
    for (int i = 0; i < total; i++) stream.push_back(seq ? 16'(i + 1) : 16'($urandom));
    src_q = stream;
    src_q.push_back(16'hDEAD);
    src_q.push_back(16'hBEEF);
    build_expected();
  endtask

  // Monitor, stream source and AXI4-Lite slave; inputs change on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_axi.awready = 1'b0;
      m_axi.wready  = 1'b0;
      m_axi.bvalid  = 1'b0;
      m_axi.bresp   = 2'b00;
      cfg_valid     = 1'b0;
      cfg_data      = 16'd0;
      aw_fire = 0; w_fire = 0; b_fire = 0; aw_done = 0; w_done = 0;
      aw_wait = 0; w_wait = 0; cfg_fire = 0; cyc = 0;
    end else begin
      if (done) done_cnt++;
      if (cfg_ready && (!busy || m_axi.awvalid || m_axi.wvalid || m_axi.bready)) proto_err++;

      if (cfg_fire) begin
        void'(src_q.pop_front());
        consumed++;
        cfg_fire = 0;
      end
      cfg_valid = (src_q.size() > 0) &&
                  ((gap_mode == 0) || (gap_mode == 1 && cyc % 3 == 0) ||
                   (gap_mode == 2 && $urandom_range(0, 1) == 1));
      cfg_data  = cfg_valid ? src_q[0] : 16'd0;
      if (cfg_valid && cfg_ready) cfg_fire = 1;
      cyc++;

      if (aw_fire) begin aw_fire = 0; aw_done = 1; end
      if (w_fire)  begin w_fire  = 0; w_done  = 1; end
      if (b_fire) begin
        b_fire       = 0;
        m_axi.bvalid = 1'b0;
        m_axi.bresp  = 2'b00;
      end
      if ((aw_done && m_axi.awvalid) || (w_done && m_axi.wvalid)) proto_err++;
      if (!aw_done && aw_wait > 0 && !m_axi.awvalid) proto_err++;
      if (!w_done && w_wait > 0 && !m_axi.wvalid) proto_err++;
      m_axi.awready = 1'b0;
      m_axi.wready  = 1'b0;
      if (aw_done && w_done && !m_axi.bvalid) begin
        log_q.push_back('{addr: cap_addr, data: cap_data});
        if (cap_addr == 32'd12 && {24'd0, cur_layer} != cap_data) proto_err++;
        m_axi.bvalid = 1'b1;
        m_axi.bresp  = (log_q.size() == err_on_write) ? 2'b10 : 2'b00;
        aw_done = 0;
        w_done  = 0;
        if (rand_delay) begin
          aw_delay = $urandom_range(0, 4);
          w_delay  = $urandom_range(0, 4);
        end
      end
      if (m_axi.awvalid && !aw_done) begin
        if (aw_wait >= aw_delay) begin
          m_axi.awready = 1'b1;
          aw_fire  = 1;
          cap_addr = m_axi.awaddr;
          aw_wait  = 0;
        end else aw_wait++;
      end
      if (m_axi.wvalid && !w_done) begin
        if (w_wait >= w_delay) begin
          m_axi.wready = 1'b1;
          w_fire   = 1;
          cap_data = m_axi.wdata;
          w_wait   = 0;
          if (m_axi.wstrb != 4'hF) proto_err++;
        end else w_wait++;
      end
      if (m_axi.bvalid && m_axi.bready) b_fire = 1;
    end
  end

  task automatic run_vec(input vec_t v);
    int  exp_n, exp_words, cycles, nchk;
    bit  restarted;
    aw_delay     = v.aw_d;
    w_delay      = v.w_d;
    rand_delay   = v.rnd_d;
    gap_mode     = v.gap;
    err_on_write = v.err_wr;
    prep_stream(v.seq_data);
    log_q.delete();
    done_cnt  = 0;
    consumed  = 0;
    proto_err = 0;
    exp_n     = (v.err_wr > 0) ? v.err_wr : exp_log.size();
    exp_words = 0;
    for (int i = 0; i < exp_n; i++)
      if (exp_log[i].addr == 32'd0 || exp_log[i].addr == 32'd4) exp_words++;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({v.name, " busy_after_start"}, 64'(busy), 64'd1);
    check({v.name, " error_cleared"}, 64'(error), 64'd0);
    check({v.name, " layer_after_start"}, 64'(cur_layer), 64'd1);

    cycles    = -1;
    restarted = 0;
    for (int n = 1; n <= 1500; n++) begin
      if (done && cycles < 0) cycles = n;
      if (error || (cycles >= 0 && n >= cycles + 4)) break;
      start = (v.restart_at > 0) && !restarted &&
              (log_q.size() == v.restart_at - 1) && m_axi.awvalid;
      if (start) restarted = 1;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    check({v.name, " write_count"}, 64'(log_q.size()), 64'(exp_n));
    nchk = (log_q.size() < exp_n) ? log_q.size() : exp_n;
    for (int i = 0; i < nchk; i++)
      check($sformatf("%s wr%0d", v.name, i + 1), {log_q[i].addr, log_q[i].data},
            {exp_log[i].addr, exp_log[i].data});
    check({v.name, " done_pulses"}, 64'(done_cnt), 64'(v.exp_done));
    check({v.name, " error"}, 64'(error), 64'(v.exp_error));
    check({v.name, " busy_end"}, 64'(busy), 64'd0);
    check({v.name, " layer_end"}, 64'(cur_layer), 64'd0);
    check({v.name, " cfg_ready_end"}, 64'(cfg_ready), 64'd0);
    check({v.name, " awvalid_end"}, 64'(m_axi.awvalid), 64'd0);
    check({v.name, " words_consumed"}, 64'(consumed), 64'(exp_words));
    check({v.name, " protocol"}, 64'(proto_err), 64'd0);
    if (v.exp_cycles > 0) check({v.name, " cycles_to_done"}, 64'(cycles), 64'(v.exp_cycles));
    if (v.restart_at > 0) check({v.name, " restart_pulsed"}, 64'(restarted), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctrl_zero"},
          64'({busy, done, error, cur_layer, cur_neuron, cfg_ready,
               m_axi.awvalid, m_axi.wvalid, m_axi.bready}), 64'd0);
    check({tag, " bus_zero"}, {m_axi.awaddr, m_axi.wdata}, 64'd0);
    check({tag, " wstrb"}, 64'(m_axi.wstrb), 64'hF);
  endtask

  vec_t vecs[7];
  vec_t after_reset;
  bit   found;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    aw_delay = 0; w_delay = 0; gap_mode = 0; err_on_write = 0; rand_delay = 0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //          name               aw w  rnd gap err rst seq cyc done err
    vecs[0] = '{"always_ready",    0, 0, 0,  0,  0,  0,  1,  79, 1,   0};
    vecs[1] = '{"aw3_w1",          3, 1, 0,  0,  0,  0,  1,  0,  1,   0};
    vecs[2] = '{"valid_1of3",      0, 0, 0,  1,  0,  0,  0,  0,  1,   0};
    vecs[3] = '{"start_ignored",   0, 0, 0,  0,  0,  10, 1,  79, 1,   0};
    vecs[4] = '{"bresp_err",       0, 0, 0,  0,  5,  0,  0,  0,  0,   1};
    vecs[5] = '{"after_error",     0, 0, 0,  0,  0,  0,  1,  79, 1,   0};
    vecs[6] = '{"random_mix",      2, 2, 1,  2,  0,  0,  0,  0,  1,   0};
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of the eighth write while its address is pending.
    aw_delay = 6; w_delay = 0; rand_delay = 0; gap_mode = 0; err_on_write = 0;
    prep_stream(1'b1);
    log_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int n = 0; n < 600; n++) begin
      if (log_q.size() == 7 && m_axi.awvalid) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("midreset reach_write8", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    after_reset = '{"after_reset", 0, 0, 0, 0, 0, 0, 1, 79, 1, 0};
    run_vec(after_reset);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
